// File: rtl/sprite_row_fetcher.sv
// Sprite row fetcher: streams one sprite row from a registered-read ROM into a
// line buffer during horizontal blanking, then replays it against draw_x with
// colour-key transparency.
module sprite_row_fetcher #(
    parameter int unsigned SprW     = 64,
    parameter int unsigned SprH     = 64,
    parameter logic [23:0] KeyColor = 24'hFF00FF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        line_start_i,
    input  logic [9:0]  next_y_i,
    input  logic [9:0]  spr_x_i,
    input  logic [9:0]  spr_y_i,
    input  logic        spr_en_i,
    input  logic [9:0]  draw_x_i,
    output logic [18:0] rom_addr_o,
    input  logic [23:0] rom_data_i,
    output logic [23:0] pixel_out_o,
    output logic        pixel_valid_o,
    output logic        busy_o
);

    localparam int unsigned ColW = $clog2(SprW);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e            state_q, state_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [9:0]        row_lat_q, row_lat_d;
    logic [9:0]        x_lat_q, x_lat_d;
    logic              line_ok_q, line_ok_d;
    logic [18:0]       addr_hold_q;
    logic              wr_en_q;
    logic [ColW-1:0]   wr_col_q;
    logic [23:0]       pixel_out_q;
    logic              pixel_valid_q;
    logic [23:0]       line_buf_q [SprW];

    logic [9:0]        row;
    logic              row_ok;
    logic [18:0]       fetch_addr;
    logic [9:0]        dx;
    logic              hit;
    logic [23:0]       rd_pix;

    // Wrapped subtraction makes next_y < spr_y land far out of range.
    assign row        = next_y_i - spr_y_i;
    assign row_ok     = spr_en_i && (32'(row) < SprH);
    assign fetch_addr = 19'(row_lat_q) * 19'(SprW) + 19'(col_q);

    // Address is live while fetching and frozen at the last issued value otherwise.
    assign rom_addr_o = (state_q == StFetch) ? fetch_addr : addr_hold_q;
    assign busy_o     = (state_q != StIdle);

    assign dx     = draw_x_i - x_lat_q;
    assign hit    = line_ok_q && (32'(dx) < SprW);
    assign rd_pix = line_buf_q[dx[ColW-1:0]];

    assign pixel_out_o   = pixel_out_q;
    assign pixel_valid_o = pixel_valid_q;

    // Next-state logic; a line_start pulse overrides whatever fetch is in flight.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_lat_d = row_lat_q;
        x_lat_d   = x_lat_q;
        line_ok_d = line_ok_q;
        if (line_start_i) begin
            x_lat_d   = spr_x_i;
            line_ok_d = 1'b0;
            if (row_ok) begin
                row_lat_d = row;
                col_d     = '0;
                state_d   = StFetch;
            end else begin
                state_d = StIdle;
            end
        end else begin
            unique case (state_q)
                StFetch: begin
                    col_d = col_q + ColW'(1);
                    if (col_q == ColW'(SprW - 1)) begin
                        state_d = StDrain;
                    end
                end
                StDrain: begin
                    line_ok_d = 1'b1;
                    state_d   = StIdle;
                end
                default: ;
            endcase
        end
    end

    // Control state, delayed write pipe and registered pixel output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            col_q         <= '0;
            row_lat_q     <= '0;
            x_lat_q       <= '0;
            line_ok_q     <= 1'b0;
            addr_hold_q   <= '0;
            wr_en_q       <= 1'b0;
            wr_col_q      <= '0;
            pixel_out_q   <= '0;
            pixel_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_lat_q     <= row_lat_d;
            x_lat_q       <= x_lat_d;
            line_ok_q     <= line_ok_d;
            if (state_q == StFetch) begin
                addr_hold_q <= fetch_addr;
            end
            // ROM data for an address arrives one cycle later; track its column.
            wr_en_q       <= (state_q == StFetch);
            wr_col_q      <= col_q;
            pixel_out_q   <= rd_pix;
            pixel_valid_q <= hit && (rd_pix != KeyColor);
        end
    end

    // Line buffer storage; contents only matter once line_ok is set.
    always_ff @(posedge clk_i) begin
        if (wr_en_q) begin
            line_buf_q[wr_col_q] <= rom_data_i;
        end
    end

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Directed testbench for sprite_row_fetcher with a one-cycle-latency ROM model
// returning data = address (optionally one address replaced by the key colour).
module tb_sprite_row_fetcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_start = 1'b0;
    logic [9:0]  next_y = '0;
    logic [9:0]  spr_x = 10'd200;
    logic [9:0]  spr_y = 10'd100;
    logic        spr_en = 1'b1;
    logic [9:0]  draw_x = '0;
    logic [18:0] rom_addr;
    logic [23:0] rom_data = '0;
    logic [23:0] pixel_out;
    logic        pixel_valid;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int key_addr = -1;

    sprite_row_fetcher dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .line_start_i (line_start),
        .next_y_i     (next_y),
        .spr_x_i      (spr_x),
        .spr_y_i      (spr_y),
        .spr_en_i     (spr_en),
        .draw_x_i     (draw_x),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .pixel_out_o  (pixel_out),
        .pixel_valid_o(pixel_valid),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Registered-read ROM model.
    always @(posedge clk) begin
        rom_data <= (int'(rom_addr) == key_addr) ? 24'hFF00FF : {5'd0, rom_addr};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // line_start is high for exactly one cycle (T); returns in cycle T+1.
    task automatic pulse(input logic [9:0] y, input logic en);
        next_y     = y;
        spr_en     = en;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        tests++;
        if (rom_addr !== 19'd0) begin
            fails++;
            $display("FAIL reset_rom_addr: got %0d want 0", rom_addr);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        tests++;
        if (pixel_valid !== 1'b0 || pixel_out !== 24'd0) begin
            fails++;
            $display("FAIL reset_pixel: got valid=%b out=%0h want 0/0", pixel_valid, pixel_out);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        pulse(10'd105, 1'b1);
        repeat (19) tick();
        tests++;
        if (rom_addr !== 19'd339 || busy !== 1'b1) begin
            fails++;
            $display("FAIL midreset_pre: got addr=%0d busy=%b want 339/1", rom_addr, busy);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (rom_addr !== 19'd0 || busy !== 1'b0 || pixel_valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_now: got addr=%0d busy=%b valid=%b want 0/0/0",
                     rom_addr, busy, pixel_valid);
        end
        tick();
        tick();
        rst = 1'b0;
        draw_x = 10'd210;
        for (int i = 0; i < 70; i++) begin
            tick();
            tests++;
            if (rom_addr !== 19'd0 || busy !== 1'b0 || pixel_valid !== 1'b0) begin
                fails++;
                $display("FAIL midreset_after: cyc %0d got addr=%0d busy=%b valid=%b want 0/0/0",
                         i, rom_addr, busy, pixel_valid);
            end
        end
    endtask

    task automatic test_fetch(input logic [9:0] y, input int base);
        pulse(y, 1'b1);
        for (int c = 0; c < 64; c++) begin
            tests++;
            if (rom_addr !== 19'(base + c) || busy !== 1'b1) begin
                fails++;
                $display("FAIL fetch_addr: col %0d got addr=%0d busy=%b want %0d/1",
                         c, rom_addr, busy, base + c);
            end
            tick();
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL fetch_drain_busy: got %b want 1", busy);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || rom_addr !== 19'(base + 63)) begin
            fails++;
            $display("FAIL fetch_done: got busy=%b addr=%0d want 0/%0d",
                     busy, rom_addr, base + 63);
        end
    endtask

    // Sweep draw_x 195..270 with x_lat = 200; key_x < 0 means no transparent pixel.
    task automatic test_sweep(input int base, input int key_x, input bit expect_any);
        for (int x = 195; x <= 270; x++) begin
            bit         in_spr;
            bit         exp_v;
            logic [23:0] exp_p;
            draw_x = 10'(x);
            tick();
            in_spr = expect_any && (x >= 200) && (x <= 263);
            exp_v  = in_spr && (x != key_x);
            exp_p  = (x == key_x) ? 24'hFF00FF : 24'(base + x - 200);
            tests++;
            if (pixel_valid !== exp_v) begin
                fails++;
                $display("FAIL sweep_valid: draw_x %0d got %b want %b", x, pixel_valid, exp_v);
            end
            if (in_spr) begin
                tests++;
                if (pixel_out !== exp_p) begin
                    fails++;
                    $display("FAIL sweep_pixel: draw_x %0d got %0h want %0h", x, pixel_out, exp_p);
                end
            end
        end
    endtask

    task automatic test_row_boundary();
        test_fetch(10'd163, 4032);
        test_sweep(4032, -1, 1'b1);
    endtask

    task automatic test_out_of_range();
        logic [9:0] ys [3];
        logic       ens [3];
        ys[0] = 10'd99;  ens[0] = 1'b1;
        ys[1] = 10'd164; ens[1] = 1'b1;
        ys[2] = 10'd110; ens[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pulse(ys[k], ens[k]);
            for (int i = 0; i < 70; i++) begin
                tests++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL oor_busy: case %0d cyc %0d got %b want 0", k, i, busy);
                end
                tick();
            end
            test_sweep(0, -1, 1'b0);
        end
    endtask

    task automatic test_restart();
        draw_x = 10'd205;
        pulse(10'd105, 1'b1);
        repeat (29) tick();
        pulse(10'd110, 1'b1);
        for (int i = 0; i < 66; i++) begin
            if (i < 64) begin
                tests++;
                if (rom_addr !== 19'(640 + i)) begin
                    fails++;
                    $display("FAIL restart_addr: col %0d got %0d want %0d", i, rom_addr, 640 + i);
                end
            end
            tests++;
            if (pixel_valid !== 1'b0) begin
                fails++;
                $display("FAIL restart_early_valid: cyc %0d got %b want 0", i + 1, pixel_valid);
            end
            tick();
        end
        tests++;
        if (pixel_valid !== 1'b1 || pixel_out !== 24'd645) begin
            fails++;
            $display("FAIL restart_first_valid: got valid=%b out=%0d want 1/645",
                     pixel_valid, pixel_out);
        end
        test_sweep(640, -1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_fetch(10'd105, 320);
        test_sweep(320, -1, 1'b1);
        key_addr = 330;
        test_fetch(10'd105, 320);
        test_sweep(320, 210, 1'b1);
        key_addr = -1;
        test_row_boundary();
        test_out_of_range();
        test_restart();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_row_fetcher.md
# sprite_row_fetcher

Read-side client for the 64x64, 24-bit sprite ROMs (4096 words, one-cycle registered read). On each scanline start it streams one sprite row out of the ROM into an internal 64-entry line buffer, absorbing the ROM's one-cycle read latency. During active video it replays that row against the VGA horizontal counter, producing a registered pixel and valid flag with colour-key transparency. It sits between the VGA controller and the colour mapper, one instance per on-screen sprite (note gems, fret buttons).

## Interface
- SPR_W, 64, sprite width in pixels (power of two)
- SPR_H, 64, sprite height in rows
- KEY_COLOR, 24'hFF00FF, transparent colour; never marked valid
- Clk  in  1  system clock; all state on rising edge
- Reset  in  1  asynchronous, active-high; one clock domain
- line_start  in  1  one-cycle pulse at the start of horizontal blanking for the line next_y
- next_y  in  10  scanline about to be displayed
- spr_x  in  10  sprite left edge, screen pixels
- spr_y  in  10  sprite top edge, screen pixels
- spr_en  in  1  sprite visible
- draw_x  in  10  current horizontal pixel counter
- rom_addr  out  19  ROM read address
- rom_data  in  24  ROM read data, valid one cycle after rom_addr
- pixel_out  out  24  registered sprite pixel
- pixel_valid  out  1  pixel_out is opaque and inside the sprite
- busy  out  1  high while in FETCH or DRAIN

## Operation
- States: IDLE, FETCH, DRAIN.
- On line_start (any state): latch spr_x into x_lat; compute row = next_y - spr_y (10-bit wrap); clear line_ok.
  - If spr_en && row < SPR_H: load row_lat = row, col = 0, go to FETCH.
  - Otherwise go to IDLE with line_ok = 0.
- line_start during FETCH/DRAIN aborts the current fetch and restarts it; the most recent pulse wins. No partial row is ever marked valid.
- FETCH: rom_addr = row_lat*SPR_W + col, zero-extended to 19 bits; col increments every cycle. After col = SPR_W-1 has been issued, go to DRAIN.
- Write-back uses a delayed column (col_d) and a delayed write-enable: buf[col_d] <= rom_data on the cycle after each address is issued.
- DRAIN: captures the final word (col 63). Then line_ok <= 1, next state IDLE.
- rom_addr holds its last value outside FETCH and resets to 0.
- Replay (every cycle): dx = draw_x - x_lat (10-bit wrap); hit = line_ok && dx < SPR_W.
  - pixel_out <= buf[dx[5:0]].
  - pixel_valid <= hit && buf[dx[5:0]] != KEY_COLOR.
- The fetch is non-destructive to the ROM; there is no write path.

## Timing
- Reset values: state IDLE, rom_addr 0, pixel_out 0, pixel_valid 0, busy 0, line_ok 0, col 0. Line-buffer contents are don't-care but are never exposed, because line_ok = 0.
- Relative to the line_start cycle T:
  - First address is issued at T+1; last address (col 63) at T+64.
  - Final write lands at T+65 (DRAIN). line_ok = 1 from T+66.
  - busy is high from T+1 through T+65 inclusive.
- Total fetch takes 65 cycles. This must fit inside horizontal blanking (160 pixel clocks at 640x480); the driving logic guarantees it.
- Replay latency is one cycle: the draw_x sampled at edge N appears on pixel_out/pixel_valid at edge N+1. The colour mapper compensates.
- Row boundaries:
  - row = SPR_H-1 is fetched.
  - row = SPR_H is not.
  - next_y < spr_y wraps to a large value, so the row is not fetched.
- Column boundaries:
  - dx = 63 is valid.
  - dx = 64 is not.
  - draw_x < x_lat wraps, so it is not valid.
- Reset asserted mid-FETCH immediately returns the block to reset values. No further ROM addresses are issued until the next line_start after Reset is released.

## Test plan
- Reset mid-fetch: assert Reset at T+20 → rom_addr = 0, busy = 0, pixel_valid = 0 immediately. No fetch resumes until the next line_start.
- Basic fetch: spr_y = 100, next_y = 105, spr_en = 1, ROM modelled as 1-cycle latency with data = address → rom_addr runs 320..383 on cycles T+1..T+64; busy deasserts at T+66; buffer entry c holds 320+c.
- Replay: after the basic fetch, spr_x = 200, sweep draw_x 195..270 → pixel_valid is high exactly for the outputs corresponding to draw_x 200..263, with pixel_out = 320+(draw_x-200), each one cycle after its draw_x.
- Transparency: same setup, ROM word 330 = 24'hFF00FF → pixel_valid = 0 at draw_x = 210 only.
- Out of range: next_y = 99, then next_y = 164, then spr_en = 0 with next_y = 110 → no FETCH, busy stays 0, pixel_valid stays 0 for all draw_x.
- Restart: second line_start at T+30 with next_y = 110 → addresses restart at 640 on the following cycle; line_ok stays 0 until 66 cycles after the second pulse; replayed data is 640..703.
